// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle control unit for the RV32I subset datapath (lw, sw, sub, xor, addi, srl, beq).
// Steps each instruction through IF/ID/EX/MEM/WB and halts on program end or illegal opcode.
module sequenciador_multiciclo #(
    parameter int unsigned N_INSTR = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        zero,
    input  logic        mem_ready,
    input  logic [31:0] pc,
    output logic [2:0]  estado,
    output logic        pcwrite,
    output logic        pcsrc,
    output logic        irwrite,
    output logic        regiwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        alusrc,
    output logic [3:0]  alucontrol,
    output logic        done,
    output logic        erro,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EX     = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_OCIOSO = 3'b101,
        S_FIM    = 3'b110
    } state_t;

    typedef enum logic [2:0] {
        C_LW, C_SW, C_SUB, C_XOR, C_SRL, C_ADDI, C_BEQ, C_ILL
    } iclass_t;

    // pc[31:2] >= N_INSTR is the same test as pc >= 4*N_INSTR on the full byte address.
    localparam logic [33:0] PC_LIMIT = 34'(N_INSTR) * 34'd4;

    function automatic iclass_t classify(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        iclass_t c;
        c = C_ILL;
        case (op)
            7'b0000011: if (f3 == 3'b010) c = C_LW;
            7'b0100011: if (f3 == 3'b010) c = C_SW;
            7'b0010011: if (f3 == 3'b000) c = C_ADDI;
            7'b1100011: if (f3 == 3'b000) c = C_BEQ;
            7'b0110011: begin
                if (f3 == 3'b000 && f7 == 7'b0100000) c = C_SUB;
                if (f3 == 3'b100 && f7 == 7'b0000000) c = C_XOR;
                if (f3 == 3'b101 && f7 == 7'b0000000) c = C_SRL;
            end
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] alu_op(input iclass_t c);
        case (c)
            C_LW, C_SW, C_ADDI: return 4'b0010;
            C_SUB, C_BEQ:       return 4'b0110;
            C_XOR:              return 4'b0011;
            C_SRL:              return 4'b0101;
            default:            return 4'b0000;
        endcase
    endfunction

    state_t      state_q;
    logic [6:0]  op_q;
    logic [2:0]  f3_q;
    logic [6:0]  f7_q;
    logic        erro_q;
    logic [15:0] count_q;

    iclass_t     cls;
    logic        halt;
    logic        uses_imm;
    logic [15:0] count_inc;

    assign cls       = classify(op_q, f3_q, f7_q);
    assign halt      = ({2'b00, pc} >= PC_LIMIT);
    assign uses_imm  = (cls == C_LW) || (cls == C_SW) || (cls == C_ADDI);
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    // NOTE: every register in this block uses <= so all of them update from the same
    // pre-edge values; a blocking = here would let later lines see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OCIOSO;
            op_q    <= '0;
            f3_q    <= '0;
            f7_q    <= '0;
            erro_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_OCIOSO: if (start) state_q <= S_IF;
                S_IF:     state_q <= halt ? S_FIM : S_ID;
                S_ID: begin
                    op_q <= opcode;
                    f3_q <= funct3;
                    f7_q <= funct7;
                    if (classify(opcode, funct3, funct7) == C_ILL) begin
                        state_q <= S_FIM;
                        erro_q  <= 1'b1;
                    end else begin
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    if (cls == C_LW || cls == C_SW) begin
                        state_q <= S_MEM;
                    end else if (cls == C_BEQ) begin
                        state_q <= S_IF;
                        count_q <= count_inc;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (cls == C_SW) begin
                            state_q <= S_IF;
                            count_q <= count_inc;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state_q <= S_IF;
                    count_q <= count_inc;
                end
                S_FIM: state_q <= S_FIM;
                default: begin
                    state_q <= S_FIM;
                    erro_q  <= 1'b1;
                end
            endcase
        end
    end

    // Outputs decode from registers only (plus zero in EX and pc in IF), so reset clears them at once.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        estado      = state_q;
        pcwrite     = 1'b0;
        pcsrc       = 1'b0;
        irwrite     = 1'b0;
        regiwrite   = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        alusrc      = 1'b0;
        alucontrol  = 4'b0000;
        done        = 1'b0;
        erro        = 1'b0;
        instr_count = count_q;
        case (state_q)
            S_IF: begin
                irwrite = !halt;
                pcwrite = !halt;
            end
            S_EX: begin
                alucontrol = alu_op(cls);
                alusrc     = uses_imm;
                if (cls == C_BEQ && zero) begin
                    pcwrite = 1'b1;
                    pcsrc   = 1'b1;
                end
            end
            S_MEM: begin
                alucontrol = alu_op(cls);
                alusrc     = uses_imm;
                memread    = (cls == C_LW);
                memwrite   = (cls == C_SW);
            end
            S_WB: begin
                regiwrite = 1'b1;
                memtoreg  = (cls == C_LW);
            end
            S_FIM: begin
                done = 1'b1;
                erro = erro_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sequenciador_multiciclo.md
# sequenciador_multiciclo

Multi-cycle control unit for the RV32I subset datapath (lw, sw, sub, xor, addi, srl, beq). It steps each instruction through IF/ID/EX/MEM/WB, drives every datapath enable and control signal, and waits on a memory ready handshake. It halts cleanly when the program ends or an unsupported instruction is decoded. It replaces the free-running top-level state loop and sits between the decoder and the PC, register-file, ALU and data-memory blocks.

## Interface
- `N_INSTR`, default 7: number of instructions in the program. Fetch stops when `pc[31:2] >= N_INSTR`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: leave OCIOSO and begin fetching.
- `opcode` input 7: from the decoder.
- `funct3` input 3: from the decoder.
- `funct7` input 7: from the decoder.
- `zero` input 1: ALU equality flag, valid in EX.
- `mem_ready` input 1: data memory has completed the access.
- `pc` input 32: current PC byte address.
- `estado` output 3: current state.
- `pcwrite` output 1: update the PC.
- `pcsrc` output 1: 1 selects PC+imm, 0 selects PC+4.
- `irwrite` output 1: latch the instruction.
- `regiwrite` output 1: register file write enable.
- `memread` output 1: data memory read strobe.
- `memwrite` output 1: data memory write strobe.
- `memtoreg` output 1: write-back source is memory.
- `alusrc` output 1: ALU B operand is the immediate.
- `alucontrol` output 4: ALU operation.
- `done` output 1: program finished.
- `erro` output 1: unsupported instruction detected.
- `instr_count` output 16: retired-instruction counter.

## Operation
- **State encoding:** IF=000, ID=001, EX=010, MEM=011, WB=100, OCIOSO=101, FIM=110. Code 111 goes to FIM with `erro`=1.
- **OCIOSO:** go to IF when `start`=1.
- **IF, halt check:** if `pc[31:2] >= N_INSTR`, go to FIM and assert no strobes.
- **IF, fetch:** otherwise assert `irwrite`=1, `pcwrite`=1 and `pcsrc`=0, then go to ID.
- **ID:** register `opcode`, `funct3` and `funct7` internally. All later control comes from these registered copies. Classify the instruction:
  - lw: 0000011 / f3 010.
  - sw: 0100011 / f3 010.
  - sub: 0110011 / f3 000 / f7 0100000.
  - xor: 0110011 / f3 100 / f7 0000000.
  - srl: 0110011 / f3 101 / f7 0000000.
  - addi: 0010011 / f3 000.
  - beq: 1100011 / f3 000.
  - Anything else: go to FIM with `erro`=1.
- **Paths:**
  - lw: IF ID EX MEM WB.
  - sw: IF ID EX MEM, then IF.
  - R-type and addi: IF ID EX WB.
  - beq: IF ID EX, then IF.
- **alucontrol** (valid in EX and MEM, 0000 elsewhere):
  - add 0010 for lw, sw and addi.
  - sub 0110 for sub and beq.
  - xor 0011.
  - srl 0101.
- **alusrc:** 1 in EX/MEM for lw, sw and addi; 0 otherwise.
- **beq in EX:** if `zero`=1, assert `pcwrite`=1 and `pcsrc`=1. The branch target is computed by the PC block from the fetched PC.
- **MEM:** hold `memread` (lw) or `memwrite` (sw) high while `mem_ready`=0. Advance on the edge where `mem_ready`=1.
- **WB:** assert `regiwrite`=1 for one cycle. `memtoreg`=1 for lw only.
- **instr_count:** increments by 1 when an instruction retires (leaving WB, sw leaving MEM, beq leaving EX). Saturates at 16'hFFFF.
- **FIM:** `done`=1; stay until reset. `start` is ignored in FIM and in all non-OCIOSO states.

## Timing
- **Outputs:** Moore outputs, decoded from `estado` and the registered instruction fields. Every strobe is high only for the cycle(s) spent in the named state.
- **Reset values:** every output 0, `estado`=OCIOSO, `instr_count`=0, internal fields 0. This holds immediately on `rst_n` low, without waiting for `clk`.
- **Reset mid-operation:** any pending strobe drops asynchronously. No partial write-back is allowed after reset is released.
- **Latency with `mem_ready` high on MEM entry:**
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and addi: 4 cycles.
  - beq: 3 cycles.
  - Each cycle of `mem_ready`=0 in MEM adds 1.
- **Handshake:** `mem_ready` is sampled only in MEM; it is ignored in other states.
- **`zero`:** sampled only in EX.
- **Halt check:** evaluated every IF cycle against `pc` as seen in that cycle. This includes the IF immediately after a taken beq.

## Test plan
- **Reset then start:** reset, `start`=1 for 1 cycle, `pc`=0, addi (0010011/000) → `estado` sequence 101,000,001,010,100,000. `irwrite` high in IF. `alusrc`=1 and `alucontrol`=0010 in EX. `regiwrite` high for exactly 1 cycle. `instr_count`=1.
- **lw with wait:** lw with `mem_ready`=0 for 2 cycles → MEM lasts 3 cycles with `memread` high throughout. Then WB with `memtoreg`=1. Total 7 cycles.
- **beq both ways:** beq with `zero`=1 → `pcwrite`=1 and `pcsrc`=1 in EX. Repeat with `zero`=0 → `pcwrite`=0 in EX. Either way the next state is IF.
- **sub and srl:** sub gives `alucontrol`=0110; srl gives 0101. No `memread`/`memwrite` at any cycle.
- **Halt conditions:**
  - Illegal opcode 1111111 → FIM after ID, `erro`=1, `done`=1. `start` pulse has no effect.
  - With `N_INSTR`=7 and `pc`=28 at IF → FIM with no `irwrite`.
- **Reset mid-access:** `rst_n` low during sw in MEM with `mem_ready`=0 → `memwrite` drops without a clock edge, `estado`=101, `instr_count`=0.
